ldpc_iter_controller: RTL

- Outer-loop controller of the LDPC decoder; drives the check-row counter stage and consumes its row index and phase outputs.
- Per decoding iteration, it releases the row counter for one check sweep and ORs the per-row syndrome parity bits from the check-node array.
- At the end of each sweep it either terminates (syndrome clean, or iteration budget exhausted) or pulses the variable-node update and starts the next sweep.
- It reports done, success and iteration count to the QKD post-processing control.

---
 rtl/ldpc_iter_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ldpc_iter_controller.sv
// ldpc_iter_controller
// Outer-loop controller of the LDPC decoder. It releases the check-row counter
// for one sweep per iteration and ORs the per-row syndrome bits. At the end of
// each sweep it either finishes the frame (clean syndrome, iteration budget
// spent, or sweep watchdog expired) or pulses the variable-node update and
// starts the next sweep. All outputs come straight from flops.
module ldpc_iter_controller #(
  parameter int log2m         = 3,
  parameter int m             = 6,
  parameter int max_iter      = 8,
  parameter int log2_max_iter = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [log2m-1:0]         check_iter_count,
  input  logic [1:0]               check_state,
  input  logic                     row_valid,
  input  logic                     row_parity,
  output logic                     ctr_rst,
  output logic                     var_update,
  output logic [log2_max_iter-1:0] iter_num,
  output logic                     busy,
  output logic                     done,
  output logic                     success,
  output logic                     err
);

  localparam int                       wd_w       = log2m + 2;
  localparam logic [wd_w-1:0]          wd_limit   = wd_w'(2 * m - 1);
  localparam logic [wd_w-1:0]          wd_one     = wd_w'(1);
  localparam logic [log2_max_iter-1:0] iter_last  = log2_max_iter'(max_iter - 1);
  localparam logic [log2_max_iter-1:0] iter_one   = log2_max_iter'(1);
  localparam logic [1:0]               phase_done = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    VUPD,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic                     ctr_rst_q, ctr_rst_d;
  logic                     var_update_q, var_update_d;
  logic [log2_max_iter-1:0] iter_num_q, iter_num_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     success_q, success_d;
  logic                     err_q, err_d;
  logic                     syn_fail_q, syn_fail_d;
  logic [wd_w-1:0]          wd_q, wd_d;
  logic                     fail_now;

  // The row index is informational only; it feeds no decision here.
  logic unused_row_index;
  assign unused_row_index = ^check_iter_count;

  // Syndrome including the row presented in the current cycle, so the row
  // sampled in the sweep's exit cycle still counts.
  assign fail_now = syn_fail_q | (row_valid & row_parity);

  // Next-state and next-output decode for the iteration FSM.
  always_comb begin
    // NOTE: every _d takes its held value first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    ctr_rst_d    = ctr_rst_q;
    var_update_d = var_update_q;
    iter_num_d   = iter_num_q;
    busy_d       = busy_q;
    done_d       = done_q;
    success_d    = success_q;
    err_d        = err_q;
    syn_fail_d   = syn_fail_q;
    wd_d         = wd_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = SWEEP;
          ctr_rst_d  = 1'b0;
          busy_d     = 1'b1;
          iter_num_d = '0;
          done_d     = 1'b0;
          success_d  = 1'b0;
          err_d      = 1'b0;
          syn_fail_d = 1'b0;
          wd_d       = '0;
        end
      end

      SWEEP: begin
        syn_fail_d = fail_now;
        wd_d       = wd_q + wd_one;
        if (check_state == phase_done) begin
          ctr_rst_d = 1'b1;
          if (!fail_now) begin
            state_d   = DONE;
            done_d    = 1'b1;
            success_d = 1'b1;
            busy_d    = 1'b0;
          end else if (iter_num_q == iter_last) begin
            state_d   = DONE;
            done_d    = 1'b1;
            success_d = 1'b0;
            busy_d    = 1'b0;
          end else begin
            state_d      = VUPD;
            var_update_d = 1'b1;
          end
        end else if (wd_q == wd_limit) begin
          // Row counter never reported the end of the sweep: give up.
          state_d   = DONE;
          ctr_rst_d = 1'b1;
          done_d    = 1'b1;
          success_d = 1'b0;
          err_d     = 1'b1;
          busy_d    = 1'b0;
        end
      end

      VUPD: begin
        state_d      = SWEEP;
        var_update_d = 1'b0;
        ctr_rst_d    = 1'b0;
        iter_num_d   = iter_num_q + iter_one;
        syn_fail_d   = 1'b0;
        wd_d         = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; an asynchronous reset abandons any frame.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (!rst) begin
      state_q      <= IDLE;
      ctr_rst_q    <= 1'b1;
      var_update_q <= 1'b0;
      iter_num_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      success_q    <= 1'b0;
      err_q        <= 1'b0;
      syn_fail_q   <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      ctr_rst_q    <= ctr_rst_d;
      var_update_q <= var_update_d;
      iter_num_q   <= iter_num_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      success_q    <= success_d;
      err_q        <= err_d;
      syn_fail_q   <= syn_fail_d;
      wd_q         <= wd_d;
    end
  end

  assign ctr_rst    = ctr_rst_q;
  assign var_update = var_update_q;
  assign iter_num   = iter_num_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign success    = success_q;
  assign err        = err_q;

endmodule
